// File: rtl/scaler_pkg.sv
// Shared types and defaults for the pitch-scaler window sequencer slice.
// Optional watchdog feature is controlled by SCALER_SEQ_TIMEOUT_EN.
package scaler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    HANDOFF = 2'd3
  } seq_state_t;

  localparam int unsigned N_BINS_DEF = 4096;
  localparam int unsigned ADDR_W_DEF = 12;

  // Saturating 16-bit counter bump by 0..2.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/scaler_window_sequencer_if.sv
// Handshake bundle between the window sequencer and the scaler / polar_to_cart path.
// timeout_err exists only when SCALER_SEQ_TIMEOUT_EN is defined.
interface scaler_window_sequencer_if
  import scaler_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              win_valid;
  logic              win_idx;
  logic [15:0]       scale_amt_in;
  logic [15:0]       scale_amt;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_wren;
  logic              scaler_go;
  logic              scaler_window;
  logic              scaler_done;
  logic              scaler_buf;
  logic              p2c_go;
  logic              p2c_buf;
  logic              p2c_done;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic [15:0]       overrun_cnt;
`ifdef SCALER_SEQ_TIMEOUT_EN
  logic              timeout_err;

  modport master (
    input  win_valid, win_idx, scale_amt_in, scaler_done, scaler_buf, p2c_done,
    output scale_amt, clr_addr, clr_wren, scaler_go, scaler_window, p2c_go, p2c_buf,
           busy, frame_cnt, overrun_cnt, timeout_err
  );
  modport slave (
    output win_valid, win_idx, scale_amt_in, scaler_done, scaler_buf, p2c_done,
    input  scale_amt, clr_addr, clr_wren, scaler_go, scaler_window, p2c_go, p2c_buf,
           busy, frame_cnt, overrun_cnt, timeout_err
  );
`else
  modport master (
    input  win_valid, win_idx, scale_amt_in, scaler_done, scaler_buf, p2c_done,
    output scale_amt, clr_addr, clr_wren, scaler_go, scaler_window, p2c_go, p2c_buf,
           busy, frame_cnt, overrun_cnt
  );
  modport slave (
    output win_valid, win_idx, scale_amt_in, scaler_done, scaler_buf, p2c_done,
    input  scale_amt, clr_addr, clr_wren, scaler_go, scaler_window, p2c_go, p2c_buf,
           busy, frame_cnt, overrun_cnt
  );
`endif
endinterface

// File: rtl/scaler_window_sequencer_synth_clear_sweeper.sv
// Zeroing sweep for synth buffers: start pulse -> wren with addr 0..N_BINS-1, no gaps.
// last is high on the cycle carrying the final address.
module synth_clear_sweeper #(
  parameter int unsigned N_BINS = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic              last
);

  assign last = wren && (addr == ADDR_W'(N_BINS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      wren <= 1'b0;
    end else if (wren) begin
      if (last) begin
        addr <= '0;
        wren <= 1'b0;
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end else if (start) begin
      addr <= '0;
      wren <= 1'b1;
    end
  end

endmodule

// File: rtl/scaler_window_sequencer.sv
// Frame scheduler for the pitch-scaler path: prime, clear synth buffers, run scaler, hand off.
// Optional RUN watchdog with sticky timeout_err under SCALER_SEQ_TIMEOUT_EN.
module scaler_window_sequencer
  import scaler_pkg::*;
#(
  parameter int unsigned N_BINS  = N_BINS_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
`ifdef SCALER_SEQ_TIMEOUT_EN
  , parameter int unsigned TMO_CYC = 16384
`endif
) (
  input logic                        clk,
  input logic                        reset,
  scaler_window_sequencer_if.master  bus
);

  seq_state_t state;
  logic       primed;
  logic       pend_v;
  logic       pend_idx;
  logic       p2c_busy;
  logic       launch;
  logic       launch_idx;
  logic       sweep_last;
  logic       timeout_hit;
  logic       overrun_hit;
  logic [1:0] ovr_inc;

  assign launch      = (state == IDLE) && primed && (bus.win_valid || pend_v);
  assign launch_idx  = pend_v ? pend_idx : bus.win_idx;
  assign overrun_hit = (state != IDLE) && bus.win_valid && pend_v;
  assign ovr_inc     = {1'b0, overrun_hit} + {1'b0, timeout_hit};
  assign bus.busy    = (state != IDLE);
  // Handoff pulse is decoded from registers so it appears the cycle HANDOFF is entered.
  assign bus.p2c_go  = (state == HANDOFF) && !p2c_busy;

  synth_clear_sweeper #(
    .N_BINS (N_BINS),
    .ADDR_W (ADDR_W)
  ) u_sweeper (
    .clk   (clk),
    .reset (reset),
    .start (launch),
    .addr  (bus.clr_addr),
    .wren  (bus.clr_wren),
    .last  (sweep_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      bus.scale_amt     <= '0;
      bus.scaler_window <= 1'b0;
      bus.scaler_go     <= 1'b0;
      bus.p2c_buf       <= 1'b0;
      bus.frame_cnt     <= '0;
    end else begin
      bus.scaler_go <= 1'b0;
      unique case (state)
        IDLE: if (launch) begin
          bus.scale_amt     <= bus.scale_amt_in;
          bus.scaler_window <= launch_idx;
          state             <= CLEAR;
        end
        CLEAR: if (sweep_last) begin
          bus.scaler_go <= 1'b1;
          state         <= RUN;
        end
        RUN: begin
          if (bus.scaler_done) begin
            bus.p2c_buf <= bus.scaler_buf;
            state       <= HANDOFF;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        HANDOFF: if (!p2c_busy) begin
          bus.frame_cnt <= bus.frame_cnt + 16'd1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep backlog; a launch that drains it may refill it from the same-cycle window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed   <= 1'b0;
      pend_v   <= 1'b0;
      pend_idx <= 1'b0;
    end else if (launch) begin
      if (pend_v) begin
        if (bus.win_valid) pend_idx <= bus.win_idx;
        else               pend_v   <= 1'b0;
      end
    end else if (bus.win_valid && state != IDLE) begin
      pend_v   <= 1'b1;
      pend_idx <= bus.win_idx;
    end else if (bus.win_valid) begin
      primed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p2c_busy        <= 1'b0;
      bus.overrun_cnt <= '0;
    end else begin
      if (bus.p2c_go)        p2c_busy <= 1'b1;
      else if (bus.p2c_done) p2c_busy <= 1'b0;
      bus.overrun_cnt <= sat_add16(bus.overrun_cnt, ovr_inc);
    end
  end

`ifdef SCALER_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign timeout_hit = (state == RUN) && !bus.scaler_done && (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt         <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == RUN && !timeout_hit) ? tmo_cnt + TMO_W'(1) : '0;
      if (timeout_hit) bus.timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_scaler_window_sequencer.sv
// Directed bench for scaler_window_sequencer: table-driven launch vectors plus frame sequences.
// Define SCALER_SEQ_TIMEOUT_EN to also exercise the RUN watchdog (TMO_CYC=64).
module tb_scaler_window_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  scaler_window_sequencer_if #(.ADDR_W(12)) bus ();

`ifdef SCALER_SEQ_TIMEOUT_EN
  scaler_window_sequencer #(.N_BINS(4096), .ADDR_W(12), .TMO_CYC(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );
`else
  scaler_window_sequencer #(.N_BINS(4096), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );
`endif

  typedef struct {
    logic        wv;
    logic        idx;
    logic [15:0] amt_in;
    logic        busy;
    logic        wren;
    logic [11:0] addr;
    logic        win;
    logic [15:0] amt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_win(input logic idx);
    bus.win_valid = 1'b1;
    bus.win_idx   = idx;
    step(1);
    bus.win_valid = 1'b0;
  endtask

  task automatic wait_go(input string name);
    int unsigned n;
    n = 0;
    while (!bus.scaler_go && n < 5000) begin
      step(1);
      n++;
    end
    check(name, 32'(bus.scaler_go), 32'd1);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_busy"}, 32'(bus.busy), 32'd0);
    check({p, "_wren"}, 32'(bus.clr_wren), 32'd0);
    check({p, "_addr"}, 32'(bus.clr_addr), 32'd0);
    check({p, "_go"}, 32'(bus.scaler_go), 32'd0);
    check({p, "_window"}, 32'(bus.scaler_window), 32'd0);
    check({p, "_amt"}, 32'(bus.scale_amt), 32'd0);
    check({p, "_p2c_go"}, 32'(bus.p2c_go), 32'd0);
    check({p, "_p2c_buf"}, 32'(bus.p2c_buf), 32'd0);
    check({p, "_frames"}, 32'(bus.frame_cnt), 32'd0);
    check({p, "_overrun"}, 32'(bus.overrun_cnt), 32'd0);
`ifdef SCALER_SEQ_TIMEOUT_EN
    check({p, "_tmo_err"}, 32'(bus.timeout_err), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned nwr;
    int unsigned bad;
    int unsigned n;
    int unsigned saw_p2c;

    bus.win_valid    = 1'b0;
    bus.win_idx      = 1'b0;
    bus.scale_amt_in = 16'h0180;
    bus.scaler_done  = 1'b0;
    bus.scaler_buf   = 1'b0;
    bus.p2c_done     = 1'b0;

    vecs[0] = '{wv:1'b0, idx:1'b0, amt_in:16'h0180, busy:1'b0, wren:1'b0, addr:12'd0, win:1'b0, amt:16'h0000};
    vecs[1] = '{wv:1'b1, idx:1'b0, amt_in:16'h0180, busy:1'b0, wren:1'b0, addr:12'd0, win:1'b0, amt:16'h0000};
    vecs[2] = '{wv:1'b0, idx:1'b0, amt_in:16'h0180, busy:1'b0, wren:1'b0, addr:12'd0, win:1'b0, amt:16'h0000};
    vecs[3] = '{wv:1'b1, idx:1'b1, amt_in:16'h0180, busy:1'b1, wren:1'b1, addr:12'd0, win:1'b1, amt:16'h0180};
    vecs[4] = '{wv:1'b0, idx:1'b0, amt_in:16'h0080, busy:1'b1, wren:1'b1, addr:12'd1, win:1'b1, amt:16'h0180};
    vecs[5] = '{wv:1'b0, idx:1'b0, amt_in:16'h0080, busy:1'b1, wren:1'b1, addr:12'd2, win:1'b1, amt:16'h0180};

    step(3);
    check_all_zero("rst");
    reset = 1'b0;

    // Priming window, then launch from window 1 with scale 0x0180.
    for (int i = 0; i < 6; i++) begin
      bus.win_valid    = vecs[i].wv;
      bus.win_idx      = vecs[i].idx;
      bus.scale_amt_in = vecs[i].amt_in;
      step(1);
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_wren", i), 32'(bus.clr_wren), 32'(vecs[i].wren));
      check($sformatf("v%0d_addr", i), 32'(bus.clr_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_window", i), 32'(bus.scaler_window), 32'(vecs[i].win));
      check($sformatf("v%0d_amt", i), 32'(bus.scale_amt), 32'(vecs[i].amt));
    end
    bus.win_valid = 1'b0;

    // Remaining clear sweep: contiguous addresses, 4096 cycles in total, then scaler_go.
    nwr = 3;
    bad = 0;
    step(1);
    while (bus.clr_wren && nwr < 5000) begin
      if (bus.clr_addr != nwr[11:0]) bad++;
      if (bus.scaler_go) bad++;
      nwr++;
      step(1);
    end
    check("clr_len", nwr, 32'd4096);
    check("clr_gaps", bad, 32'd0);
    check("go_after_clear", 32'(bus.scaler_go), 32'd1);
    check("go_window", 32'(bus.scaler_window), 32'd1);
    step(1);
    check("go_single", 32'(bus.scaler_go), 32'd0);
    check("amt_held_run", 32'(bus.scale_amt), 32'h0180);
    step(5);

    // Frame 1 handoff with polar_to_cart idle.
    bus.scaler_done = 1'b1;
    bus.scaler_buf  = 1'b1;
    step(1);
    bus.scaler_done = 1'b0;
    bus.scaler_buf  = 1'b0;
    check("f1_p2c_go", 32'(bus.p2c_go), 32'd1);
    check("f1_p2c_buf", 32'(bus.p2c_buf), 32'd1);
    step(1);
    check("f1_p2c_go_end", 32'(bus.p2c_go), 32'd0);
    check("f1_frames", 32'(bus.frame_cnt), 32'd1);
    check("f1_idle", 32'(bus.busy), 32'd0);

    // scaler_done outside RUN is ignored.
    bus.scaler_done = 1'b1;
    step(1);
    bus.scaler_done = 1'b0;
    step(1);
    check("stray_done_busy", 32'(bus.busy), 32'd0);
    check("stray_done_buf", 32'(bus.p2c_buf), 32'd1);
    check("stray_done_frames", 32'(bus.frame_cnt), 32'd1);

    // Frame 2: new scale latched at launch; three windows arrive during RUN.
    pulse_win(1'b1);
    check("f2_busy", 32'(bus.busy), 32'd1);
    check("f2_amt", 32'(bus.scale_amt), 32'h0080);
    check("f2_window", 32'(bus.scaler_window), 32'd1);
    wait_go("f2_go");
    pulse_win(1'b0);
    pulse_win(1'b1);
    pulse_win(1'b0);
    check("f2_overrun", 32'(bus.overrun_cnt), 32'd2);
    check("f2_window_stable", 32'(bus.scaler_window), 32'd1);

    // polar_to_cart still busy from frame 1: handoff must wait for p2c_done.
    bus.scaler_done = 1'b1;
    bus.scaler_buf  = 1'b1;
    step(1);
    bus.scaler_done = 1'b0;
    bus.scaler_buf  = 1'b0;
    check("f2_held0", 32'(bus.p2c_go), 32'd0);
    step(3);
    check("f2_held3", 32'(bus.p2c_go), 32'd0);
    check("f2_held_busy", 32'(bus.busy), 32'd1);
    bus.p2c_done = 1'b1;
    step(1);
    bus.p2c_done = 1'b0;
    check("f2_p2c_go", 32'(bus.p2c_go), 32'd1);
    check("f2_p2c_buf", 32'(bus.p2c_buf), 32'd1);
    step(1);
    check("f2_frames", 32'(bus.frame_cnt), 32'd2);
    check("f2_idle", 32'(bus.busy), 32'd0);

    // Frame 3 launches from the pending entry (newest window, idx 0).
    step(1);
    check("f3_busy", 32'(bus.busy), 32'd1);
    check("f3_window", 32'(bus.scaler_window), 32'd0);
    check("f3_wren", 32'(bus.clr_wren), 32'd1);
    check("f3_overrun", 32'(bus.overrun_cnt), 32'd2);

    // Reset in the middle of the clear sweep.
    n = 0;
    while (bus.clr_addr != 12'd1000 && n < 5000) begin
      step(1);
      n++;
    end
    check("mid_addr_1000", 32'(bus.clr_addr), 32'd1000);
    reset = 1'b1;
    #1;
    check_all_zero("mid");
    step(1);
    reset = 1'b0;
    step(1);

    pulse_win(1'b1);
    check("reprime_busy", 32'(bus.busy), 32'd0);
    check("reprime_wren", 32'(bus.clr_wren), 32'd0);
    step(2);
    check("reprime_idle", 32'(bus.busy), 32'd0);
    pulse_win(1'b0);
    check("relaunch_busy", 32'(bus.busy), 32'd1);
    check("relaunch_window", 32'(bus.scaler_window), 32'd0);
    check("relaunch_wren", 32'(bus.clr_wren), 32'd1);

`ifdef SCALER_SEQ_TIMEOUT_EN
    // No scaler_done: the watchdog drops the frame after 64 RUN cycles.
    wait_go("tmo_go");
    n = 0;
    saw_p2c = 0;
    while (bus.busy && n < 200) begin
      if (bus.p2c_go) saw_p2c++;
      n++;
      step(1);
    end
    check("tmo_run_cycles", n, 32'd64);
    check("tmo_no_p2c", saw_p2c, 32'd0);
    check("tmo_err", 32'(bus.timeout_err), 32'd1);
    check("tmo_overrun", 32'(bus.overrun_cnt), 32'd1);
    check("tmo_frames", 32'(bus.frame_cnt), 32'd0);
`else
    saw_p2c = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
